// File: rtl/rv32imf_obi_pkg.sv
// Shared types and constants for the RV32IMF OBI-to-SRAM data bridge.
package rv32imf_obi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        in_range;
  } req_t;

  localparam logic [31:0] OOR_RDATA       = 32'h0;
  localparam int unsigned MAX_WAIT_STATES = 15;

  typedef logic [$clog2(MAX_WAIT_STATES + 1)-1:0] wait_cnt_t;

endpackage

// File: rtl/rv32imf_obi_sram_bridge.sv
// Core data-port slave: OBI req/gnt/rvalid to single-port synchronous SRAM.
// Optional RV32IMF_OBI_BRIDGE_RDATA_HOLD_EN keeps rdata_o at the last response between responses.
module rv32imf_obi_sram_bridge
  import rv32imf_obi_pkg::*;
#(
  parameter int unsigned DEPTH       = 16384,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  output logic          gnt_o,
  output logic          rvalid_o,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic          sram_req_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i
);

  logic        run_q;
  logic        in_range;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        unused_addr_lsb;

  assign in_range        = {2'b00, addr_i[31:2]} < DEPTH;
  assign unused_addr_lsb = ^addr_i[1:0];

  // Keeps grants (and hence SRAM strobes) low while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  if (WAIT_STATES == 0) begin : g_pipe
    logic accept;
    logic rvalid_q;
    logic rd_q;

    assign gnt_o        = run_q;
    assign accept       = req_i & run_q;
    assign sram_req_o   = accept & in_range;
    assign sram_we_o    = sram_req_o & we_i;
    assign sram_be_o    = sram_req_o ? be_i : '0;
    assign sram_addr_o  = sram_req_o ? addr_i[AW+1:2] : '0;
    assign sram_wdata_o = sram_req_o ? wdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rd_q     <= 1'b0;
      end else begin
        rvalid_q <= accept;
        rd_q     <= accept & ~we_i & in_range;
      end
    end

    assign resp_valid = rvalid_q;
    assign resp_data  = rd_q ? sram_rdata_i : OOR_RDATA;
  end else begin : g_fsm
    state_e    state_q, state_d;
    wait_cnt_t cnt_q, cnt_d;
    req_t      lat_q, lat_d;
    logic      access;
    logic      unused_lat_addr;

    assign unused_lat_addr = ^lat_q.addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        lat_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lat_q   <= lat_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      gnt_o   = 1'b0;
      unique case (state_q)
        StIdle: begin
          gnt_o = req_i & run_q;
          if (req_i & run_q) begin
            lat_d.we       = we_i;
            lat_d.be       = be_i;
            lat_d.addr     = addr_i[31:2];
            lat_d.wdata    = wdata_i;
            lat_d.in_range = in_range;
            cnt_d          = wait_cnt_t'(WAIT_STATES - 1);
            state_d        = StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_d = StAccess;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StAccess: state_d = StResp;
        StResp:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    assign access       = (state_q == StAccess) & lat_q.in_range;
    assign sram_req_o   = access;
    assign sram_we_o    = access & lat_q.we;
    assign sram_be_o    = access ? lat_q.be : '0;
    assign sram_addr_o  = access ? lat_q.addr[AW-1:0] : '0;
    assign sram_wdata_o = access ? lat_q.wdata : '0;

    assign resp_valid = (state_q == StResp);
    assign resp_data  = (lat_q.in_range & ~lat_q.we) ? sram_rdata_i : OOR_RDATA;
  end

  assign rvalid_o = resp_valid;

`ifdef RV32IMF_OBI_BRIDGE_RDATA_HOLD_EN
  logic [31:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (resp_valid) begin
      hold_q <= resp_data;
    end
  end

  assign rdata_o = resp_valid ? resp_data : hold_q;
`else
  assign rdata_o = resp_valid ? resp_data : '0;
`endif

endmodule

// File: tb/tb_rv32imf_obi_sram_bridge.sv
// Bench for rv32imf_obi_sram_bridge: four configurations against a word-array memory model.
module tb_rv32imf_obi_sram_bridge;

  localparam int NI   = 4;
  localparam int MAXW = 128;
  localparam int unsigned DEP [NI] = '{128, 16, 16, 16};
  localparam int unsigned WST [NI] = '{0, 0, 3, 2};

  logic        clk = 1'b0;
  logic        rst_n  [NI];
  logic        req    [NI];
  logic        gnt    [NI];
  logic        rvalid [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic [31:0] rdata  [NI];
  logic        sreq   [NI];
  logic        swe    [NI];
  logic [3:0]  sbe    [NI];
  logic [31:0] saddr  [NI];
  logic [31:0] swdata [NI];
  logic [31:0] srdata [NI];

  logic [31:0] ref_mem [NI][MAXW];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned AW = $clog2(DEP[g]);
    logic [AW-1:0] sa;
    logic [31:0]   mem [DEP[g]];
    int            sreq_cnt = 0;

    rv32imf_obi_sram_bridge #(
      .DEPTH      (DEP[g]),
      .WAIT_STATES(WST[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n[g]),
      .req_i       (req[g]),
      .gnt_o       (gnt[g]),
      .rvalid_o    (rvalid[g]),
      .we_i        (we[g]),
      .be_i        (be[g]),
      .addr_i      (addr[g]),
      .wdata_i     (wdata[g]),
      .rdata_o     (rdata[g]),
      .sram_req_o  (sreq[g]),
      .sram_we_o   (swe[g]),
      .sram_be_o   (sbe[g]),
      .sram_addr_o (sa),
      .sram_wdata_o(swdata[g]),
      .sram_rdata_i(srdata[g])
    );

    assign saddr[g] = 32'(sa);

    initial for (int k = 0; k < int'(DEP[g]); k++) mem[k] <= '0;

    always @(posedge clk) begin
      if (sreq[g]) begin
        sreq_cnt <= sreq_cnt + 1;
        if (swe[g]) begin
          for (int b = 0; b < 4; b++) if (sbe[g][b]) mem[sa][8*b +: 8] <= swdata[g][8*b +: 8];
        end else begin
          srdata[g] <= mem[sa];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int i, input logic [31:0] a);
    return {2'b00, a[31:2]} < DEP[i];
  endfunction

  // One complete transaction: wait for grant, drop req, measure latency, check data, update model.
  task automatic xact(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] obs);
    int n;
    int unsigned exp_lat;
    logic [31:0] exp_d;
    exp_lat = (WST[i] == 0) ? 1 : WST[i] + 2;
    exp_d   = (!w && in_rng(i, a)) ? ref_mem[i][a[8:2]] : 32'h0;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    #1;
    n = 0;
    while (gnt[i] !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("gnt_within_bound", 32'(n < 20), 32'd1);
    tick();
    req[i] = 1'b0; we[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
    n = 1;
    while (rvalid[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("rvalid_latency", 32'(n), exp_lat);
    check("rdata", rdata[i], exp_d);
    obs = rdata[i];
    if (w && in_rng(i, a)) begin
      for (int k = 0; k < 4; k++) if (b[k]) ref_mem[i][a[8:2]][8*k +: 8] = d[8*k +: 8];
    end
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] gv, rv, expg, expv, rd5;
    int          cnt0, nrv, ii;
    logic [31:0] ra;

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b1; we[i] = 1'b1; be[i] = 4'hF;
      addr[i] = 32'h4; wdata[i] = 32'hFFFF_FFFF;
      for (int k = 0; k < MAXW; k++) ref_mem[i][k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_gnt", 32'(gnt[i]), 32'd0);
      check("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'd0);
      check("rst_sram_req", 32'(sreq[i]), 32'd0);
      check("rst_sram_we", 32'(swe[i]), 32'd0);
      check("rst_sram_be", 32'(sbe[i]), 32'd0);
      check("rst_sram_addr", saddr[i], 32'd0);
      check("rst_sram_wdata", swdata[i], 32'd0);
      req[i] = 1'b0; we[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
      rst_n[i] = 1'b1;
    end
    repeat (2) tick();

    // Pipelined write then read on consecutive cycles.
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h100; wdata[0] = 32'h1234_5678;
    #1;
    check("pipe_gnt_c0", 32'(gnt[0]), 32'd1);
    check("pipe_sreq_c0", 32'(sreq[0]), 32'd1);
    tick();
    we[0] = 1'b0; wdata[0] = '0;
    #1;
    check("pipe_gnt_c1", 32'(gnt[0]), 32'd1);
    check("pipe_rvalid_c1", 32'(rvalid[0]), 32'd1);
    check("pipe_rdata_c1", rdata[0], 32'd0);
    tick();
    req[0] = 1'b0; addr[0] = '0; be[0] = '0;
    #1;
    check("pipe_rvalid_c2", 32'(rvalid[0]), 32'd1);
    check("pipe_rdata_c2", rdata[0], 32'h1234_5678);
    tick();
    check("pipe_rvalid_c3", 32'(rvalid[0]), 32'd0);
    ref_mem[0][64] = 32'h1234_5678;

    // Byte-enable merge and empty byte-enable write.
    xact(0, 1'b1, 4'hF, 32'h40, 32'h1122_3344, r);
    xact(0, 1'b1, 4'b0101, 32'h40, 32'hAABB_CCDD, r);
    xact(0, 1'b0, 4'hF, 32'h40, 32'h0, r);
    check("be_merge", r, 32'h11BB_33DD);
    xact(0, 1'b1, 4'h0, 32'h40, 32'hFFFF_FFFF, r);
    xact(0, 1'b0, 4'hF, 32'h40, 32'h0, r);
    check("be_zero_keeps", r, 32'h11BB_33DD);

    // rdata behaviour between responses.
    xact(0, 1'b1, 4'hF, 32'h80, 32'hCAFE_F00D, r);
    xact(0, 1'b0, 4'hF, 32'h80, 32'h0, r);
    for (int c = 0; c < 3; c++) begin
`ifdef RV32IMF_OBI_BRIDGE_RDATA_HOLD_EN
      check("rdata_idle_hold", rdata[0], 32'hCAFE_F00D);
`else
      check("rdata_idle_zero", rdata[0], 32'h0);
`endif
      tick();
    end

    // WAIT_STATES=3 with req held: grant/response cadence.
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h8;
    gv = '0; rv = '0; expg = '0; expv = '0; rd5 = 'x;
    for (int c = 0; c < 12; c++) begin
      #1;
      gv[c] = gnt[2];
      rv[c] = rvalid[2];
      if (c == 5) rd5 = rdata[2];
      expg[c] = (c % (WST[2] + 3)) == 0;
      expv[c] = (c % (WST[2] + 3)) == WST[2] + 2;
      tick();
    end
    req[2] = 1'b0; addr[2] = '0; be[2] = '0;
    check("ws3_gnt_pattern", gv, expg);
    check("ws3_rvalid_pattern", rv, expv);
    check("ws3_rdata", rd5, ref_mem[2][2]);
    repeat (8) tick();

    // Out-of-range accesses on DEPTH=16.
    xact(1, 1'b1, 4'hF, 32'h0, 32'h5A5A_5A5A, r);
    cnt0 = g_inst[1].sreq_cnt;
    xact(1, 1'b0, 4'hF, 32'h40, 32'h0, r);
    check("oor_read_zero", r, 32'h0);
    xact(1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, r);
    check("oor_no_sram_req", 32'(g_inst[1].sreq_cnt), 32'(cnt0));
    xact(1, 1'b0, 4'hF, 32'h0, 32'h0, r);
    check("oor_word0_intact", r, 32'h5A5A_5A5A);

    // Reset during WAIT on WAIT_STATES=2.
    req[3] = 1'b1; we[3] = 1'b0; be[3] = 4'hF; addr[3] = 32'h4;
    #1;
    check("rstw_gnt", 32'(gnt[3]), 32'd1);
    tick();
    #2;
    rst_n[3] = 1'b0;
    #1;
    check("rstw_gnt_low", 32'(gnt[3]), 32'd0);
    check("rstw_rvalid_low", 32'(rvalid[3]), 32'd0);
    check("rstw_sreq_low", 32'(sreq[3]), 32'd0);
    check("rstw_rdata_low", rdata[3], 32'd0);
    req[3] = 1'b0; addr[3] = '0; be[3] = '0;
    tick();
    rst_n[3] = 1'b1;
    nrv = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rvalid[3] === 1'b1) nrv++;
      tick();
    end
    check("rstw_no_rvalid", 32'(nrv), 32'd0);
    xact(3, 1'b1, 4'hF, 32'h4, 32'h0102_0304, r);
    xact(3, 1'b0, 4'hF, 32'h4, 32'h0, r);
    check("rstw_after_release", r, 32'h0102_0304);

    // Randomised traffic across three configurations.
    for (int t = 0; t < 60; t++) begin
      ii = (t % 3 == 0) ? 2 : ((t % 3 == 1) ? 0 : 1);
      ra = $urandom_range(0, DEP[ii] * 4 + 31) & ~32'h3;
      xact(ii, 1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32imf_obi_sram_bridge.md
Name: rv32imf_obi_sram_bridge

Overview:
Data-side memory slave sitting directly downstream of the RV32IMF top-level data port. It accepts the core's req/gnt/rvalid transactions and converts them into single-port synchronous SRAM accesses (1-cycle read latency). Insertion of wait states is configurable. Out-of-range accesses are absorbed so the core never hangs.

Parameters:
DEPTH, 16384, SRAM size in 32-bit words; power of two, >= 2; AW = $clog2(DEPTH).
WAIT_STATES, 0, extra cycles between grant and SRAM access; range 0..15.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  core data request
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid, exactly one per granted request
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables
addr_i  in  32  byte address; bits [1:0] ignored
wdata_i  in  32  write data
rdata_o  out  32  read data
sram_req_o  out  1  SRAM chip enable
sram_we_o  out  1  SRAM write enable
sram_be_o  out  4  SRAM byte enables
sram_addr_o  out  AW  SRAM word address
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid the cycle after sram_req_o&~sram_we_o

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_ni). All state clears immediately on rst_ni low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, sram_req_o=0, sram_we_o=0, sram_be_o=0, sram_addr_o=0, sram_wdata_o=0. FSM=IDLE, wait counter=0.
- In range: addr_i[31:2] < DEPTH. Out-of-range accesses are granted and answered, with no SRAM access. Read data for them is 32'h0; writes are dropped.
- WAIT_STATES==0 (pipelined path, no FSM):
  - gnt_o=1 every cycle out of reset.
  - sram_* driven combinationally from the request: sram_req_o = req_i & in_range.
  - rvalid_o registered one cycle after req_i&gnt_o. rdata_o = sram_rdata_i for reads, 0 for writes/out-of-range.
  - Back-to-back requests give 1 transaction/cycle.
- WAIT_STATES>0, FSM states IDLE, WAIT, ACCESS, RESP:
  - IDLE: gnt_o=req_i. On req_i, latch we/be/addr/wdata/in_range, load counter=WAIT_STATES-1, go WAIT.
  - WAIT: gnt_o=0. Decrement counter; when counter==0, go ACCESS.
  - ACCESS: drive sram_* from latched regs (sram_req_o=latched in_range), go RESP.
  - RESP: rvalid_o=1 for one cycle with rdata as above; go IDLE. No grant in RESP.
  - Latency from grant to rvalid_o = WAIT_STATES+2 cycles; throughput one transaction per WAIT_STATES+3 cycles.
- req_i deasserted while in WAIT/ACCESS/RESP has no effect; the latched transaction completes.
- Writes apply be_i per byte; be_i=0 performs an SRAM cycle with no bytes written, and rvalid still issues.
- Reset mid-transaction: the pending response is discarded and no rvalid_o is issued after reset release.
- No error response; the core side has no err signal.

Optional Feature:
Macro RV32IMF_OBI_BRIDGE_RDATA_HOLD_EN.
- Defined: rdata_o is registered and holds the last response value while rvalid_o=0.
- Undefined: rdata_o forced to 32'h0 whenever rvalid_o=0.
- Reset value is 0 in both cases.

Decomposition:
- Package rv32imf_obi_pkg holds:
  - state enum typedef (IDLE, WAIT, ACCESS, RESP);
  - packed request struct (we, be, addr, wdata, in_range) used for the latch;
  - OOR_RDATA constant (32'h0);
  - MAX_WAIT_STATES constant (15).
- No sub-module; the wait counter and FSM are inline. Generate-if selects the pipelined or FSM path.

Test Plan:
- WAIT_STATES=0, write 0x12345678 be=4'hF to 0x100, then read 0x100 in the next cycle -> both granted immediately; rvalid on cycles 1 and 2; read data 0x12345678.
- WAIT_STATES=0, write 0xAABBCCDD be=4'b0101 over 0x11223344 at 0x40, then read -> 0x11BB33DD.
- WAIT_STATES=3, read 0x8 with req_i held -> gnt at cycle 0 only, rvalid at cycle 5, next gnt no earlier than cycle 6.
- DEPTH=16, read 0x40 (word 16) -> sram_req_o never high, rvalid one cycle later (WAIT_STATES=0) with rdata 0; write to 0x40 leaves word 0 unchanged.
- WAIT_STATES=2, rst_ni low in WAIT -> outputs zero asynchronously; no rvalid after release; next request served normally.
- Macro on/off, read 0xCAFEF00D then idle 3 cycles -> rdata_o stays 0xCAFEF00D (defined) / returns to 0 (undefined).
